soc_addr_map_unit: RTL and testbench

Runtime-programmable SoC address map that replaces the fixed compile-time region/attribute constants with a register-backed rule table. Lookups pass through a 2-stage valid/ready pipeline and return the target slave index plus execute, cached and idempotent attributes. The block sits between the core/interconnect request path and the crossbar demux. A sticky lock freezes the table after boot firmware has configured it.

---
 rtl/soc_addr_map_unit.sv | 270 +++++++++++++++++++++++++++
 tb/tb_soc_addr_map_unit.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_addr_map_unit.sv
// soc_addr_map_unit: runtime-programmable SoC address map.
// A register-backed rule table (base/length/ctrl per rule) translates lookup
// addresses into a target slave index plus exec/cached/idem attributes via a
// 2-stage valid/ready pipeline. A sticky lock freezes the table after boot.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_req_i/we_i        config strobe / write enable
//   cfg_addr_i            {rule index, field[1:0]}; index NrRules = lock register
//   cfg_wdata_i           config write data
//   cfg_rvalid_o          response one cycle after each cfg_req_i
//   cfg_rdata_o/err_o     read data / error, qualified by cfg_rvalid_o
//   locked_o              table locked
//   lkp_valid_i/ready_o   lookup request handshake, lkp_addr_i address
//   res_valid_o/ready_i   result handshake
//   res_target_o/hit_o    matched target (DefaultTarget on miss) / hit flag
//   res_exec_o/cached_o/idem_o  attributes of the matched rule
module soc_addr_map_unit #(
  parameter int unsigned NrRules       = 8,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned TgtWidth      = 3,
  parameter int unsigned DefaultTarget = 1,
  parameter logic [NrRules-1:0][63:0] RstBase = {
    64'h0, 64'h0, 64'h0, 64'h0001_0000,
    64'h0200_0000, 64'h0C00_0000, 64'h4000_0000, 64'h8000_0000},
  parameter logic [NrRules-1:0][63:0] RstLength = {
    64'h0, 64'h0, 64'h1000, 64'h1_0000,
    64'hC_0000, 64'h3FF_FFFF, 64'h1000_0000, 64'h4000_0000},
  parameter logic [NrRules-1:0][15:0] RstCtrl = {
    16'h0000, 16'h0000, 16'h050B, 16'h040F,
    16'h0309, 16'h0209, 16'h0109, 16'h000F}
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cfg_req_i,
  input  logic                            cfg_we_i,
  input  logic [$clog2(NrRules+1)+1:0]    cfg_addr_i,
  input  logic [63:0]                     cfg_wdata_i,
  output logic                            cfg_rvalid_o,
  output logic [63:0]                     cfg_rdata_o,
  output logic                            cfg_err_o,
  output logic                            locked_o,
  input  logic                            lkp_valid_i,
  output logic                            lkp_ready_o,
  input  logic [AddrWidth-1:0]            lkp_addr_i,
  output logic                            res_valid_o,
  input  logic                            res_ready_i,
  output logic [TgtWidth-1:0]             res_target_o,
  output logic                            res_hit_o,
  output logic                            res_exec_o,
  output logic                            res_cached_o,
  output logic                            res_idem_o
);

  localparam int unsigned IdxW = $clog2(NrRules + 1);

  // Rule table
  logic [63:0]         base_q [NrRules];
  logic [63:0]         base_d [NrRules];
  logic [63:0]         len_q  [NrRules];
  logic [63:0]         len_d  [NrRules];
  logic [TgtWidth-1:0] tgt_q  [NrRules];
  logic [TgtWidth-1:0] tgt_d  [NrRules];
  logic [NrRules-1:0]  en_q, en_d, ex_q, ex_d, ca_q, ca_d, id_q, id_d;
  logic                lock_q, lock_d;

  // Config response
  logic                cfg_rvalid_q, cfg_rvalid_d;
  logic [63:0]         cfg_rdata_q, cfg_rdata_d;
  logic                cfg_err_q, cfg_err_d;

  // Pipeline
  logic                 s1_valid_q, s1_valid_d;
  logic [AddrWidth-1:0] s1_addr_q, s1_addr_d;
  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_hit_q, s2_hit_d;
  logic [TgtWidth-1:0]  s2_tgt_q, s2_tgt_d;
  logic                 s2_ex_q, s2_ex_d, s2_ca_q, s2_ca_d, s2_id_q, s2_id_d;

  logic [IdxW-1:0]      cfg_idx;
  logic [1:0]           cfg_fld;
  logic                 idx_is_lock, idx_is_rule;
  logic                 s1_advance_c;
  logic [63:0]          addr64;
  logic [NrRules-1:0]   match;
  logic                 m_hit, m_ex, m_ca, m_id;
  logic [TgtWidth-1:0]  m_tgt;

  assign cfg_idx     = cfg_addr_i[IdxW+1:2];
  assign cfg_fld     = cfg_addr_i[1:0];
  assign idx_is_lock = (cfg_idx == IdxW'(NrRules));
  assign idx_is_rule = (cfg_idx < IdxW'(NrRules));

  // Config decode: table/lock updates and the registered response
  always_comb begin
    base_d       = base_q;
    len_d        = len_q;
    tgt_d        = tgt_q;
    en_d         = en_q;
    ex_d         = ex_q;
    ca_d         = ca_q;
    id_d         = id_q;
    lock_d       = lock_q;
    cfg_rvalid_d = cfg_req_i;
    cfg_rdata_d  = '0;
    cfg_err_d    = 1'b0;
    if (cfg_req_i) begin
      if (idx_is_lock) begin
        if (cfg_fld != 2'd0) begin
          cfg_err_d = 1'b1;
        end else if (cfg_we_i) begin
          if (lock_q) cfg_err_d = 1'b1;
          else if (cfg_wdata_i[0]) lock_d = 1'b1;
        end else begin
          cfg_rdata_d = {63'b0, lock_q};
        end
      end else if (!idx_is_rule || cfg_fld == 2'd3) begin
        cfg_err_d = 1'b1;
      end else if (cfg_we_i && lock_q) begin
        cfg_err_d = 1'b1;
      end else begin
        for (int i = 0; i < NrRules; i++) begin
          if (cfg_idx == IdxW'(i)) begin
            if (cfg_we_i) begin
              case (cfg_fld)
                2'd0: base_d[i] = cfg_wdata_i;
                2'd1: len_d[i]  = cfg_wdata_i;
                default: begin
                  en_d[i]  = cfg_wdata_i[0];
                  ex_d[i]  = cfg_wdata_i[1];
                  ca_d[i]  = cfg_wdata_i[2];
                  id_d[i]  = cfg_wdata_i[3];
                  tgt_d[i] = cfg_wdata_i[8 +: TgtWidth];
                end
              endcase
            end else begin
              case (cfg_fld)
                2'd0: cfg_rdata_d = base_q[i];
                2'd1: cfg_rdata_d = len_q[i];
                default: begin
                  cfg_rdata_d[0]            = en_q[i];
                  cfg_rdata_d[1]            = ex_q[i];
                  cfg_rdata_d[2]            = ca_q[i];
                  cfg_rdata_d[3]            = id_q[i];
                  cfg_rdata_d[8 +: TgtWidth] = tgt_q[i];
                end
              endcase
            end
          end
        end
      end
    end
  end

  // Per-rule range compare; subtraction only taken when addr >= base so it never wraps
  assign addr64 = 64'(s1_addr_q);
  always_comb begin
    match = '0;
    for (int i = 0; i < NrRules; i++) begin
      match[i] = en_q[i] && (len_q[i] != 64'd0) && (addr64 >= base_q[i]) &&
                 ((addr64 - base_q[i]) < len_q[i]);
    end
  end

  // Priority encode: scan downward so the lowest matching index is applied last
  always_comb begin
    m_hit = 1'b0;
    m_tgt = TgtWidth'(DefaultTarget);
    m_ex  = 1'b0;
    m_ca  = 1'b0;
    m_id  = 1'b0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (match[i]) begin
        m_hit = 1'b1;
        m_tgt = tgt_q[i];
        m_ex  = ex_q[i];
        m_ca  = ca_q[i];
        m_id  = id_q[i];
      end
    end
  end

  // Pipeline control
  assign s1_advance_c = !s2_valid_q || res_ready_i;
  assign lkp_ready_o  = !s1_valid_q || s1_advance_c;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s2_valid_d = s2_valid_q;
    s2_hit_d   = s2_hit_q;
    s2_tgt_d   = s2_tgt_q;
    s2_ex_d    = s2_ex_q;
    s2_ca_d    = s2_ca_q;
    s2_id_d    = s2_id_q;
    if (lkp_ready_o) begin
      s1_valid_d = lkp_valid_i;
      if (lkp_valid_i) s1_addr_d = lkp_addr_i;
    end
    if (s1_advance_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_hit_d = m_hit;
        s2_tgt_d = m_tgt;
        s2_ex_d  = m_ex;
        s2_ca_d  = m_ca;
        s2_id_d  = m_id;
      end
    end
  end

  // State registers; reset reloads the table defaults and flushes the pipeline
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i];
        len_q[i]  <= RstLength[i];
        en_q[i]   <= RstCtrl[i][0];
        ex_q[i]   <= RstCtrl[i][1];
        ca_q[i]   <= RstCtrl[i][2];
        id_q[i]   <= RstCtrl[i][3];
        tgt_q[i]  <= RstCtrl[i][8 +: TgtWidth];
      end
      lock_q       <= 1'b0;
      cfg_rvalid_q <= 1'b0;
      cfg_rdata_q  <= '0;
      cfg_err_q    <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_hit_q     <= 1'b0;
      s2_tgt_q     <= '0;
      s2_ex_q      <= 1'b0;
      s2_ca_q      <= 1'b0;
      s2_id_q      <= 1'b0;
    end else begin
      base_q       <= base_d;
      len_q        <= len_d;
      tgt_q        <= tgt_d;
      en_q         <= en_d;
      ex_q         <= ex_d;
      ca_q         <= ca_d;
      id_q         <= id_d;
      lock_q       <= lock_d;
      cfg_rvalid_q <= cfg_rvalid_d;
      cfg_rdata_q  <= cfg_rdata_d;
      cfg_err_q    <= cfg_err_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s2_valid_q   <= s2_valid_d;
      s2_hit_q     <= s2_hit_d;
      s2_tgt_q     <= s2_tgt_d;
      s2_ex_q      <= s2_ex_d;
      s2_ca_q      <= s2_ca_d;
      s2_id_q      <= s2_id_d;
    end
  end

  assign cfg_rvalid_o = cfg_rvalid_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign cfg_err_o    = cfg_err_q;
  assign locked_o     = lock_q;
  assign res_valid_o  = s2_valid_q;
  assign res_hit_o    = s2_hit_q;
  assign res_target_o = s2_tgt_q;
  assign res_exec_o   = s2_ex_q;
  assign res_cached_o = s2_ca_q;
  assign res_idem_o   = s2_id_q;

endmodule

// File: tb/tb_soc_addr_map_unit.sv
// Self-checking bench for soc_addr_map_unit: directed lookups, config/lock,
// back-pressure, randomized stream and mid-flight reset, scored via a queue.
module tb_soc_addr_map_unit;

  localparam int unsigned NR = 8;
  localparam int unsigned IW = 4;

  typedef struct packed {
    logic       hit;
    logic [2:0] tgt;
    logic       ex;
    logic       ca;
    logic       id;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_req_i, cfg_we_i;
  logic [IW+1:0] cfg_addr_i;
  logic [63:0]   cfg_wdata_i;
  logic          cfg_rvalid_o;
  logic [63:0]   cfg_rdata_o;
  logic          cfg_err_o, locked_o;
  logic          lkp_valid_i, lkp_ready_o;
  logic [63:0]   lkp_addr_i;
  logic          res_valid_o, res_ready_i;
  logic [2:0]    res_target_o;
  logic          res_hit_o, res_exec_o, res_cached_o, res_idem_o;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  res_t mon_got, mon_exp;

  logic [63:0] m_base [NR];
  logic [63:0] m_len  [NR];
  logic [15:0] m_ctrl [NR];
  logic        m_lock;

  always #5 clk = ~clk;

  soc_addr_map_unit dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o), .locked_o(locked_o),
    .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_addr_i(lkp_addr_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_target_o(res_target_o), .res_hit_o(res_hit_o), .res_exec_o(res_exec_o),
    .res_cached_o(res_cached_o), .res_idem_o(res_idem_o)
  );

  function automatic res_t mk(logic h, logic [2:0] t, logic x, logic c, logic i);
    res_t r;
    r.hit = h; r.tgt = t; r.ex = x; r.ca = c; r.id = i;
    return r;
  endfunction

  task automatic model_reset();
    m_base = '{64'h8000_0000, 64'h4000_0000, 64'h0C00_0000, 64'h0200_0000,
               64'h0001_0000, 64'h0, 64'h0, 64'h0};
    m_len  = '{64'h4000_0000, 64'h1000_0000, 64'h3FF_FFFF, 64'hC_0000,
               64'h1_0000, 64'h1000, 64'h0, 64'h0};
    m_ctrl = '{16'h000F, 16'h0109, 16'h0209, 16'h0309,
               16'h040F, 16'h050B, 16'h0000, 16'h0000};
    m_lock = 1'b0;
  endtask

  function automatic res_t model_lookup(logic [63:0] a);
    res_t r;
    r = mk(1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = NR - 1; i >= 0; i--) begin
      if (m_ctrl[i][0] && m_len[i] != 64'd0 && a >= m_base[i] && (a - m_base[i]) < m_len[i])
        r = mk(1'b1, m_ctrl[i][10:8], m_ctrl[i][1], m_ctrl[i][2], m_ctrl[i][3]);
    end
    return r;
  endfunction

  // Result monitor: handshakes are sampled on the falling edge
  always @(negedge clk) begin
    if (!rst && res_valid_o && res_ready_i) begin
      mon_got = mk(res_hit_o, res_target_o, res_exec_o, res_cached_o, res_idem_o);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got=%b", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL lookup_result got={hit,tgt,x,c,i}=%b exp=%b", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [63:0] a, input res_t e);
    bit ok = 1'b0;
    lkp_addr_i  = a;
    lkp_valid_i = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (lkp_ready_o) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL lookup_accept_timeout addr=%h", a);
    end
    tick();
    lkp_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic cfg(input logic we, input int idx, input logic [1:0] fld,
                     input logic [63:0] wd, output logic [63:0] rd, output logic er);
    cfg_req_i   = 1'b1;
    cfg_we_i    = we;
    cfg_addr_i  = {IW'(idx), fld};
    cfg_wdata_i = wd;
    tick();
    cfg_req_i = 1'b0;
    cfg_we_i  = 1'b0;
    checks++;
    if (cfg_rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL cfg_rvalid got=%b required=1", cfg_rvalid_o);
    end
    rd = cfg_rdata_o;
    er = cfg_err_o;
    if (we && !m_lock) begin
      if (idx == NR && fld == 2'd0) m_lock = m_lock | wd[0];
      else if (idx < NR && fld == 2'd0) m_base[idx] = wd;
      else if (idx < NR && fld == 2'd1) m_len[idx] = wd;
      else if (idx < NR && fld == 2'd2) m_ctrl[idx] = wd[15:0] & 16'h070F;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_req_i = 0; cfg_we_i = 0; cfg_addr_i = '0; cfg_wdata_i = '0;
    lkp_valid_i = 0; lkp_addr_i = '0; res_ready_i = 1'b1;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({res_valid_o, cfg_rvalid_o, locked_o, res_hit_o, res_target_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=0", {res_valid_o, cfg_rvalid_o, locked_o, res_hit_o, res_target_o});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (lkp_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got ready=%b valid=%b required 1/0", lkp_ready_o, res_valid_o);
    end
  endtask

  task automatic test_defaults();
    logic [63:0] rd;
    logic er;
    cfg(1'b0, 0, 2'd0, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h8000_0000 || er !== 1'b0) begin
      errors++; $display("FAIL rd_rule0_base got=%h err=%b required 80000000/0", rd, er);
    end
    cfg(1'b0, 4, 2'd2, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h040F || er !== 1'b0) begin
      errors++; $display("FAIL rd_rule4_ctrl got=%h err=%b required 040f/0", rd, er);
    end
    do_lookup(64'h8000_1000, mk(1, 3'd0, 1, 1, 1));
    tick();
    checks++;
    if (res_valid_o !== 1'b1) begin
      errors++; $display("FAIL latency2 res_valid got=%b required=1", res_valid_o);
    end
    do_lookup(64'h0001_0004, mk(1, 3'd4, 1, 1, 1));
    do_lookup(64'h3000_0000, mk(0, 3'd1, 0, 0, 0));
    do_lookup(64'hBFFF_FFFF, mk(1, 3'd0, 1, 1, 1));
    do_lookup(64'hC000_0000, mk(0, 3'd1, 0, 0, 0));
    do_lookup(64'h0000_0FFF, mk(1, 3'd5, 1, 0, 1));
    do_lookup(64'h0FFF_FFFE, mk(1, 3'd2, 0, 0, 1));
    do_lookup(64'h0FFF_FFFF, mk(0, 3'd1, 0, 0, 0));
    drain();
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [4];
    res_t        exps  [4];
    int          acc_cyc [4];
    int          acc = 0;
    addrs = '{64'h8000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000};
    exps  = '{mk(1, 3'd0, 1, 1, 1), mk(1, 3'd4, 1, 1, 1),
              mk(1, 3'd3, 0, 0, 1), mk(1, 3'd2, 0, 0, 1)};
    lkp_valid_i = 1'b1;
    lkp_addr_i  = addrs[0];
    for (int cyc = 0; cyc < 30 && acc < 4; cyc++) begin
      res_ready_i = (cyc >= 5);
      @(negedge clk);
      if (lkp_ready_o) begin
        exp_q.push_back(exps[acc]);
        acc_cyc[acc] = cyc;
        acc++;
      end
      if (cyc == 4) begin
        checks++;
        if (acc !== 2 || lkp_ready_o !== 1'b0) begin
          errors++; $display("FAIL stall_accepts got=%0d ready=%b required 2/0", acc, lkp_ready_o);
        end
        checks++;
        if (res_valid_o !== 1'b1 || res_target_o !== 3'd0 || res_hit_o !== 1'b1) begin
          errors++; $display("FAIL stall_hold got valid=%b tgt=%0d required 1/0", res_valid_o, res_target_o);
        end
      end
      tick();
      if (acc < 4) lkp_addr_i = addrs[acc];
    end
    lkp_valid_i = 1'b0;
    res_ready_i = 1'b1;
    checks++;
    if (acc !== 4 || acc_cyc[2] !== 5 || acc_cyc[3] !== 6) begin
      errors++; $display("FAIL resume_rate accepted=%0d c2=%0d c3=%0d required 4/5/6", acc, acc_cyc[2], acc_cyc[3]);
    end
    drain();
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 20))
      0:  return 64'h8000_0000;
      1:  return 64'hBFFF_FFFF;
      2:  return 64'hC000_0000;
      3:  return 64'h7FFF_FFFF;
      4:  return 64'h4000_0000;
      5:  return 64'h4FFF_FFFF;
      6:  return 64'h5000_0000;
      7:  return 64'h0C00_0000;
      8:  return 64'h0FFF_FFFE;
      9:  return 64'h0FFF_FFFF;
      10: return 64'h0200_0000;
      11: return 64'h020B_FFFF;
      12: return 64'h020C_0000;
      13: return 64'h0001_0000;
      14: return 64'h0001_FFFF;
      15: return 64'h0002_0000;
      16: return 64'h0;
      17: return 64'h0FFF;
      18: return 64'h1000;
      19: return 64'($urandom());
      default: return {32'($urandom()), 32'($urandom())};
    endcase
  endfunction

  task automatic test_random();
    int  sent = 0;
    bit  accepted;
    lkp_valid_i = 1'b1;
    lkp_addr_i  = pick();
    for (int cyc = 0; cyc < 400 && sent < 50; cyc++) begin
      res_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      accepted = lkp_valid_i && lkp_ready_o;
      if (accepted) begin
        exp_q.push_back(model_lookup(lkp_addr_i));
        sent++;
      end
      tick();
      if (accepted || !lkp_valid_i) begin
        lkp_valid_i = ($urandom_range(0, 3) != 0);
        lkp_addr_i  = pick();
      end
    end
    lkp_valid_i = 1'b0;
    res_ready_i = 1'b1;
    drain();
  endtask

  task automatic test_program();
    logic [63:0] rd;
    logic er;
    cfg(1'b1, 6, 2'd0, 64'h8000_0000, rd, er);
    cfg(1'b1, 6, 2'd1, 64'h1000, rd, er);
    cfg(1'b1, 6, 2'd2, 64'h0501, rd, er);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL wr_rule6_err got=%b required=0", er); end
    do_lookup(64'h8000_0800, mk(1, 3'd0, 1, 1, 1));
    drain();
    cfg(1'b1, 0, 2'd2, 64'h000E, rd, er);
    do_lookup(64'h8000_0800, mk(1, 3'd5, 0, 0, 0));
    do_lookup(64'h8000_1000, mk(0, 3'd1, 0, 0, 0));
    drain();
    // rule7 region end overflows 64 bits; must not alias low addresses
    cfg(1'b1, 7, 2'd0, 64'hFFFF_FFFF_FFFF_F000, rd, er);
    cfg(1'b1, 7, 2'd1, 64'h3000, rd, er);
    cfg(1'b1, 7, 2'd2, 64'hFFFF_FFFF_FFFF_F6F1, rd, er);
    cfg(1'b0, 7, 2'd2, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h0601 || er !== 1'b0) begin
      errors++; $display("FAIL ctrl_mask got=%h err=%b required 0601/0", rd, er);
    end
    do_lookup(64'hFFFF_FFFF_FFFF_FFFF, mk(1, 3'd6, 0, 0, 0));
    do_lookup(64'h0000_0000_0000_1800, mk(0, 3'd1, 0, 0, 0));
    drain();
  endtask

  task automatic test_lock();
    logic [63:0] rd;
    logic er;
    cfg(1'b1, 9, 2'd0, 64'h1, rd, er);
    checks++;
    if (er !== 1'b1 || locked_o !== 1'b0) begin
      errors++; $display("FAIL wr_bad_index err=%b locked=%b required 1/0", er, locked_o);
    end
    cfg(1'b1, 8, 2'd0, 64'h1, rd, er);
    checks++;
    if (er !== 1'b0 || locked_o !== 1'b1) begin
      errors++; $display("FAIL lock_set err=%b locked=%b required 0/1", er, locked_o);
    end
    cfg(1'b1, 1, 2'd0, 64'h1234, rd, er);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL wr_locked_err got=%b required=1", er); end
    cfg(1'b0, 1, 2'd0, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h4000_0000 || er !== 1'b0) begin
      errors++; $display("FAIL locked_readback got=%h err=%b required 40000000/0", rd, er);
    end
    cfg(1'b1, 2, 2'd3, 64'h5, rd, er);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL wr_field3_err got=%b required=1", er); end
    cfg(1'b0, 3, 2'd3, 64'h0, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 64'h0) begin
      errors++; $display("FAIL rd_field3 got=%h err=%b required 0/1", rd, er);
    end
    cfg(1'b0, 9, 2'd0, 64'h0, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 64'h0) begin
      errors++; $display("FAIL rd_bad_index got=%h err=%b required 0/1", rd, er);
    end
    cfg(1'b1, 8, 2'd0, 64'h0, rd, er);
    cfg(1'b0, 8, 2'd0, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h1 || locked_o !== 1'b1) begin
      errors++; $display("FAIL lock_sticky got=%h locked=%b required 1/1", rd, locked_o);
    end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] rd;
    logic er;
    res_ready_i = 1'b0;
    lkp_valid_i = 1'b1;
    lkp_addr_i  = 64'h8000_0000;
    tick();
    lkp_addr_i  = 64'h0001_0000;
    tick();
    lkp_valid_i = 1'b0;
    checks++;
    if (res_valid_o !== 1'b1) begin
      errors++; $display("FAIL inflight_valid got=%b required=1", res_valid_o);
    end
    rst = 1'b1;
    exp_q.delete();
    tick();
    checks++;
    if (res_valid_o !== 1'b0 || locked_o !== 1'b0) begin
      errors++; $display("FAIL midflight_reset valid=%b locked=%b required 0/0", res_valid_o, locked_o);
    end
    rst = 1'b0;
    res_ready_i = 1'b1;
    model_reset();
    tick();
    tick();
    checks++;
    if (res_valid_o !== 1'b0) begin
      errors++; $display("FAIL dropped_result valid=%b required=0", res_valid_o);
    end
    cfg(1'b0, 0, 2'd2, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h000F) begin errors++; $display("FAIL rst_rule0_ctrl got=%h required=000f", rd); end
    cfg(1'b0, 6, 2'd0, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h0) begin errors++; $display("FAIL rst_rule6_base got=%h required=0", rd); end
    cfg(1'b0, 8, 2'd0, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h0) begin errors++; $display("FAIL rst_lock got=%h required=0", rd); end
    do_lookup(64'h8000_0800, mk(1, 3'd0, 1, 1, 1));
    drain();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_back_to_back();
    test_random();
    test_program();
    test_lock();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
